// File: rtl/i8_out_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module : i8_out_pack_pkg
// Desc   : Shared types and the byte-lane/word-split helper for the int8 output packer
// Rev    : 1.0  initial release
// ============================================================================
package i8_out_pack_pkg;

  localparam int c_NCH_MAX = 4;

  typedef logic signed [7:0] s8_t;
  typedef logic [31:0]       u32_t;

  // Entries are always stored at the widest lane count; unused lanes carry zeros.
  typedef struct packed {
    u32_t                    adr;
    logic [8*c_NCH_MAX-1:0]  d;
    logic [c_NCH_MAX-1:0]    m;
  } pack_ent_t;

  localparam int c_ENT_W = $bits(pack_ent_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WRLO = 2'd2,
    WRHI = 2'd3
  } wst_t;

  typedef struct packed {
    u32_t        lo_adr;
    u32_t        hi_adr;
    logic [31:0] lo_wd;
    logic [31:0] hi_wd;
    logic [3:0]  lo_be;
    logic [3:0]  hi_be;
  } wpair_t;

  function automatic wpair_t split_ent(input pack_ent_t e);
    wpair_t      r;
    logic [31:0] dm;
    logic [7:0]  be8;
    logic [63:0] d64;
    logic [1:0]  sh;
    sh = e.adr[1:0];
    for (int i = 0; i < c_NCH_MAX; i++) begin
      dm[8*i +: 8] = e.d[8*i +: 8] & {8{e.m[i]}};
    end
    be8 = {4'b0000, e.m} << sh;
    d64 = {32'd0, dm} << {sh, 3'b000};
    r.lo_adr = {e.adr[31:2], 2'b00};
    r.hi_adr = r.lo_adr + 32'd4;
    r.lo_wd  = d64[31:0];
    r.hi_wd  = d64[63:32];
    r.lo_be  = be8[3:0];
    r.hi_be  = be8[7:4];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i8_out_pack_if.sv
`default_nettype none
// ============================================================================
// Module : i8_out_pack_if
// Desc   : MAC-group capture and output-memory write bundle of the packer
// Rev    : 1.0  initial release
// ============================================================================
interface i8_out_pack_if #(
  parameter int NCH = 4
);
  logic               acvalid;
  logic [8*NCH-1:0]   accd;
  logic [NCH-1:0]     lmask;
  logic [31:0]        oadr;
  logic               afull;
  logic               full;
  logic               ovf;
  logic               mem_wreq;
  logic [31:0]        mem_adr;
  logic [31:0]        mem_wd;
  logic [3:0]         mem_be;
  logic               mem_wack;
  logic               busy;
  logic [15:0]        wcount;

  // master: MAC lanes plus memory responder; slave: the packer itself
  modport master (
    output acvalid, accd, lmask, oadr, mem_wack,
    input  afull, full, ovf, mem_wreq, mem_adr, mem_wd, mem_be, busy, wcount
  );

  modport slave (
    input  acvalid, accd, lmask, oadr, mem_wack,
    output afull, full, ovf, mem_wreq, mem_adr, mem_wd, mem_be, busy, wcount
  );
endinterface
`default_nettype wire

// File: rtl/i8_sfifo.sv
`default_nettype none
// ============================================================================
// Module : i8_sfifo
// Desc   : Synchronous FIFO with registered read data, full/almost-full and count
// Rev    : 1.0  initial release
// ============================================================================
module i8_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AFTH  = 2
) (
  input  logic             clk,
  input  logic             xreset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             afull,
  output logic [$clog2(DEPTH):0] count,
  output logic             push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_AFTH  = (AW+1)'(AFTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             w_rd;
  logic             w_wr;
  logic [AW:0]      w_free;

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_rd   = pop && (r_count != '0);
  assign w_wr   = push && ((r_count != c_DEPTH) || w_rd);
  assign w_free = c_DEPTH - r_count;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata   = r_rdata;
  assign full    = (r_count == c_DEPTH);
  assign afull   = (w_free <= c_AFTH);
  assign count   = r_count;
  assign push_ok = w_wr && !clr;

endmodule
`default_nettype wire

// File: rtl/i8_out_pack.sv
`default_nettype none
// ============================================================================
// Module : i8_out_pack
// Desc   : Buffers clamped s8 MAC groups and drains them as aligned 32-bit writes
// Rev    : 1.0  initial release
// ============================================================================
module i8_out_pack
  import i8_out_pack_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int FD   = 8,
  parameter int AFTH = 2
) (
  input  logic          clk,
  input  logic          xreset,
  input  logic          clr,
  i8_out_pack_if.slave  bus
);

  localparam int AW = $clog2(FD);

  logic [8*c_NCH_MAX-1:0] w_d_ext;
  logic [c_NCH_MAX-1:0]   w_m_ext;
  pack_ent_t              w_ent_in;
  pack_ent_t              w_head;
  logic [c_ENT_W-1:0]     w_rdata;
  wpair_t                 w_split;
  logic                   w_push;
  logic                   w_push_ok;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_afull;
  logic [AW:0]            w_count;
  logic                   w_empty;
  logic                   w_drop;
  logic                   w_wreq;
  logic                   w_load;
  logic                   w_adv_hi;

  wst_t                   r_state;
  wst_t                   w_next;
  logic [31:0]            r_adr;
  logic [31:0]            r_wd;
  logic [3:0]             r_be;
  logic [31:0]            r_hi_adr;
  logic [31:0]            r_hi_wd;
  logic [3:0]             r_hi_be;
  logic                   r_ovf;
  logic [15:0]            r_wcount;

  // Widen the lane bundle to the package entry width; absent lanes read as masked off.
  for (genvar i = 0; i < c_NCH_MAX; i++) begin : g_lane
    if (i < NCH) begin : g_used
      assign w_d_ext[8*i +: 8] = bus.accd[8*i +: 8];
      assign w_m_ext[i]        = bus.lmask[i];
    end else begin : g_pad
      assign w_d_ext[8*i +: 8] = 8'd0;
      assign w_m_ext[i]        = 1'b0;
    end
  end

  assign w_ent_in = '{adr: bus.oadr, d: w_d_ext, m: w_m_ext};
  assign w_push   = bus.acvalid && (bus.lmask != '0) && !clr;
  assign w_drop   = w_push && !w_push_ok;

  i8_sfifo #(
    .WIDTH (c_ENT_W),
    .DEPTH (FD),
    .AFTH  (AFTH)
  ) u_fifo (
    .clk     (clk),
    .xreset  (xreset),
    .clr     (clr),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   (w_ent_in),
    .rdata   (w_rdata),
    .full    (w_full),
    .afull   (w_afull),
    .count   (w_count),
    .push_ok (w_push_ok)
  );

  assign w_empty = (w_count == '0);
  assign w_head  = pack_ent_t'(w_rdata);
  assign w_split = split_ent(w_head);
  assign w_wreq  = (r_state == WRLO) || (r_state == WRHI);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_load   = 1'b0;
    w_adv_hi = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = (w_split.lo_be != 4'd0) ? WRLO : WRHI;
      end
      WRLO: begin
        if (bus.mem_wack) begin
          if (r_hi_be != 4'd0) begin
            w_adv_hi = 1'b1;
            w_next   = WRHI;
          end else if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = LOAD;
          end else begin
            w_next = IDLE;
          end
        end
      end
      WRHI: begin
        if (bus.mem_wack) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = LOAD;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (clr) begin
      w_next   = IDLE;
      w_pop    = 1'b0;
      w_load   = 1'b0;
      w_adv_hi = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_adr    <= '0;
      r_wd     <= '0;
      r_be     <= '0;
      r_hi_adr <= '0;
      r_hi_wd  <= '0;
      r_hi_be  <= '0;
      r_ovf    <= 1'b0;
      r_wcount <= '0;
    end else if (clr) begin
      r_adr    <= '0;
      r_wd     <= '0;
      r_be     <= '0;
      r_hi_adr <= '0;
      r_hi_wd  <= '0;
      r_hi_be  <= '0;
      r_ovf    <= 1'b0;
      r_wcount <= '0;
    end else begin
      if (w_load) begin
        r_hi_adr <= w_split.hi_adr;
        r_hi_wd  <= w_split.hi_wd;
        r_hi_be  <= w_split.hi_be;
        if (w_split.lo_be != 4'd0) begin
          r_adr <= w_split.lo_adr;
          r_wd  <= w_split.lo_wd;
          r_be  <= w_split.lo_be;
        end else begin
          r_adr <= w_split.hi_adr;
          r_wd  <= w_split.hi_wd;
          r_be  <= w_split.hi_be;
        end
      end else if (w_adv_hi) begin
        r_adr <= r_hi_adr;
        r_wd  <= r_hi_wd;
        r_be  <= r_hi_be;
      end
      if (w_wreq && bus.mem_wack) begin
        r_wcount <= r_wcount + 16'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.afull    = w_afull;
  assign bus.full     = w_full;
  assign bus.ovf      = r_ovf;
  assign bus.mem_wreq = w_wreq;
  assign bus.mem_adr  = r_adr;
  assign bus.mem_wd   = r_wd;
  assign bus.mem_be   = r_be;
  assign bus.busy     = !w_empty || (r_state != IDLE);
  assign bus.wcount   = r_wcount;

endmodule
`default_nettype wire

// File: tb/tb_i8_out_pack.sv
`default_nettype none
// ============================================================================
// Module : tb_i8_out_pack
// Desc   : Directed self-checking bench for the int8 output packer
// Rev    : 1.0  initial release
// ============================================================================
module tb_i8_out_pack;

  logic clk = 1'b0;
  logic xreset;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  int   exp_wc = 0;

  i8_out_pack_if #(.NCH(4)) bus ();

  i8_out_pack #(
    .NCH  (4),
    .FD   (8),
    .AFTH (2)
  ) dut (
    .clk    (clk),
    .xreset (xreset),
    .clr    (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] m);
    bus.oadr    = adr;
    bus.accd    = d;
    bus.lmask   = m;
    bus.acvalid = 1'b1;
    tick();
    bus.acvalid = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, then accept it with a one-cycle wack.
  task automatic expect_write(input string tag, input logic [31:0] adr,
                              input logic [31:0] wd, input logic [3:0] be);
    int n;
    n = 0;
    while (bus.mem_wreq !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " wreq"}, 32'(bus.mem_wreq), 32'd1);
    chk({tag, " adr"},  bus.mem_adr, adr);
    chk({tag, " wd"},   bus.mem_wd,  wd);
    chk({tag, " be"},   32'(bus.mem_be), 32'(be));
    bus.mem_wack = 1'b1;
    tick();
    bus.mem_wack = 1'b0;
    exp_wc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    xreset       = 1'b0;
    clr          = 1'b0;
    bus.acvalid  = 1'b0;
    bus.accd     = '0;
    bus.lmask    = '0;
    bus.oadr     = '0;
    bus.mem_wack = 1'b0;
    repeat (2) tick();

    chk("rst afull",  32'(bus.afull),    32'd0);
    chk("rst full",   32'(bus.full),     32'd0);
    chk("rst ovf",    32'(bus.ovf),      32'd0);
    chk("rst wreq",   32'(bus.mem_wreq), 32'd0);
    chk("rst adr",    bus.mem_adr,       32'd0);
    chk("rst wd",     bus.mem_wd,        32'd0);
    chk("rst be",     32'(bus.mem_be),   32'd0);
    chk("rst busy",   32'(bus.busy),     32'd0);
    chk("rst wcount", 32'(bus.wcount),   32'd0);
    xreset = 1'b1;
    tick();

    // Aligned group with wack held high: request appears two cycles after the strobe.
    bus.mem_wack = 1'b1;
    push(32'h100, 32'h847F01FF, 4'hF);
    chk("t1 wreq c0", 32'(bus.mem_wreq), 32'd0);
    tick();
    chk("t1 wreq c1", 32'(bus.mem_wreq), 32'd0);
    chk("t1 busy c1", 32'(bus.busy),     32'd1);
    tick();
    chk("t1 wreq c2", 32'(bus.mem_wreq), 32'd1);
    chk("t1 adr",     bus.mem_adr,       32'h100);
    chk("t1 wd",      bus.mem_wd,        32'h847F01FF);
    chk("t1 be",      32'(bus.mem_be),   32'hF);
    tick();
    exp_wc = 1;
    chk("t1 wreq c3", 32'(bus.mem_wreq), 32'd0);
    chk("t1 wcount",  32'(bus.wcount),   32'd1);
    chk("t1 busy c3", 32'(bus.busy),     32'd0);

    // wack without a request must not count.
    repeat (2) tick();
    bus.mem_wack = 1'b0;
    chk("idle wack wcount", 32'(bus.wcount), 32'd1);

    // Unaligned group straddling two words.
    push(32'h203, 32'h04030201, 4'hF);
    expect_write("t2 lo", 32'h200, 32'h01000000, 4'h8);
    expect_write("t2 hi", 32'h204, 32'h00040302, 4'h7);
    chk("t2 wcount", 32'(bus.wcount), 32'(exp_wc));

    // Partial group, then an all-masked group that must be ignored.
    push(32'h10, 32'hAABBCCDD, 4'h3);
    expect_write("t3", 32'h10, 32'h0000CCDD, 4'h3);
    push(32'h40, 32'h11223344, 4'h0);
    repeat (4) tick();
    chk("t3 m0 busy",   32'(bus.busy),     32'd0);
    chk("t3 m0 wreq",   32'(bus.mem_wreq), 32'd0);
    chk("t3 m0 wcount", 32'(bus.wcount),   32'(exp_wc));

    // Hole in the lane mask: the disabled byte must read back as zero.
    push(32'h20, 32'h44332211, 4'h5);
    expect_write("t4", 32'h20, 32'h00330011, 4'h5);

    // High word of the top-of-memory group wraps to address 0.
    push(32'hFFFFFFFE, 32'h44332211, 4'hF);
    expect_write("t5 lo", 32'hFFFFFFFC, 32'h22110000, 4'hC);
    expect_write("t5 hi", 32'h00000000, 32'h00004433, 4'h3);

    // Backpressure: head write stalls, then ten groups fill an 8-deep FIFO.
    push(32'h300, 32'hCAFE0000, 4'hF);
    repeat (3) tick();
    chk("bp head wreq", 32'(bus.mem_wreq), 32'd1);
    for (int k = 0; k < 10; k++) begin
      push(32'h400 + 32'(4*k), 32'hA0000000 + 32'(k), 4'hF);
      chk($sformatf("bp afull %0d", k), 32'(bus.afull), 32'(k + 1 >= 6));
      chk($sformatf("bp full %0d", k),  32'(bus.full),  32'(k + 1 >= 8));
      chk($sformatf("bp ovf %0d", k),   32'(bus.ovf),   32'(k + 1 >= 9));
    end
    chk("bp hold wreq", 32'(bus.mem_wreq), 32'd1);
    chk("bp hold adr",  bus.mem_adr,       32'h300);
    chk("bp hold wd",   bus.mem_wd,        32'hCAFE0000);
    expect_write("bp head", 32'h300, 32'hCAFE0000, 4'hF);
    for (int k = 0; k < 8; k++) begin
      expect_write($sformatf("bp q%0d", k), 32'h400 + 32'(4*k), 32'hA0000000 + 32'(k), 4'hF);
    end
    chk("bp busy",   32'(bus.busy),   32'd0);
    chk("bp ovf",    32'(bus.ovf),    32'd1);
    chk("bp wcount", 32'(bus.wcount), 32'(exp_wc));

    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_wc = 0;
    chk("clr ovf",    32'(bus.ovf),    32'd0);
    chk("clr wcount", 32'(bus.wcount), 32'd0);

    // Push and pop on the same edge while full: push is accepted, no overflow.
    push(32'h500, 32'h55555555, 4'hF);
    repeat (2) tick();
    for (int k = 0; k < 8; k++) begin
      push(32'h600 + 32'(4*k), 32'hB0000000 + 32'(k), 4'hF);
    end
    chk("pp full pre", 32'(bus.full), 32'd1);
    chk("pp head adr", bus.mem_adr,   32'h500);
    bus.oadr     = 32'h700;
    bus.accd     = 32'hC0C0C0C0;
    bus.lmask    = 4'hF;
    bus.acvalid  = 1'b1;
    bus.mem_wack = 1'b1;
    tick();
    bus.acvalid  = 1'b0;
    bus.mem_wack = 1'b0;
    exp_wc++;
    chk("pp full",   32'(bus.full),   32'd1);
    chk("pp ovf",    32'(bus.ovf),    32'd0);
    chk("pp wcount", 32'(bus.wcount), 32'(exp_wc));
    for (int k = 0; k < 8; k++) begin
      expect_write($sformatf("pp q%0d", k), 32'h600 + 32'(4*k), 32'hB0000000 + 32'(k), 4'hF);
    end
    expect_write("pp new", 32'h700, 32'hC0C0C0C0, 4'hF);
    chk("pp wcount end", 32'(bus.wcount), 32'd10);
    chk("pp busy end",   32'(bus.busy),   32'd0);

    // clr mid-write beats a coincident wack and acvalid.
    push(32'h800, 32'h12345678, 4'hF);
    repeat (2) tick();
    chk("clr mid wreq pre", 32'(bus.mem_wreq), 32'd1);
    clr          = 1'b1;
    bus.oadr     = 32'h900;
    bus.lmask    = 4'hF;
    bus.acvalid  = 1'b1;
    bus.mem_wack = 1'b1;
    tick();
    clr          = 1'b0;
    bus.acvalid  = 1'b0;
    bus.mem_wack = 1'b0;
    exp_wc = 0;
    chk("clr mid wreq",   32'(bus.mem_wreq), 32'd0);
    chk("clr mid busy",   32'(bus.busy),     32'd0);
    chk("clr mid wcount", 32'(bus.wcount),   32'd0);
    chk("clr mid ovf",    32'(bus.ovf),      32'd0);
    repeat (3) tick();
    chk("clr mid busy later", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-write.
    push(32'hA00, 32'h0F0F0F0F, 4'hF);
    expect_write("ar pre", 32'hA00, 32'h0F0F0F0F, 4'hF);
    chk("ar pre wcount", 32'(bus.wcount), 32'd1);
    push(32'hA04, 32'h0E0E0E0E, 4'hF);
    repeat (2) tick();
    chk("ar wreq pre", 32'(bus.mem_wreq), 32'd1);
    #2;
    xreset = 1'b0;
    #1;
    chk("ar wreq",   32'(bus.mem_wreq), 32'd0);
    chk("ar busy",   32'(bus.busy),     32'd0);
    chk("ar wcount", 32'(bus.wcount),   32'd0);
    chk("ar ovf",    32'(bus.ovf),      32'd0);
    chk("ar adr",    bus.mem_adr,       32'd0);
    @(negedge clk);
    xreset = 1'b1;
    tick();
    chk("ar busy after", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
